// File: rtl/mc_frame_avg.sv
// mc_frame_avg: element-wise average of 2^NF_LOG2 successive complex frames
// of 2^LEN_LOG2 samples, streamed out once the last trial frame has landed.
// Samples arriving while the averaged frame is being unloaded are discarded
// and flagged on the sticky err_drop output.
module mc_frame_avg #(
  parameter int DW       = 16,
  parameter int NF_LOG2  = 3,
  parameter int LEN_LOG2 = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic signed [DW-1:0] in_real,
  input  logic signed [DW-1:0] in_img,
  output logic                in_ready,
  output logic                out_valid,
  output logic signed [DW-1:0] out_real,
  output logic signed [DW-1:0] out_img,
  output logic [LEN_LOG2-1:0] out_idx,
  output logic                err_drop
);

  // Accumulators carry NF_LOG2 guard bits so the sum of all trials never wraps.
  localparam int AW    = DW + NF_LOG2;
  localparam int DEPTH = 1 << LEN_LOG2;

  localparam logic [0:0] ST_ACCUM = 1'b0;
  localparam logic [0:0] ST_DUMP  = 1'b1;

  logic [0:0]          state;
  logic [LEN_LOG2-1:0] s_cnt;
  logic [NF_LOG2-1:0]  f_cnt;
  // One extra bit so the pointer can sit one step past the last entry while
  // the final averaged sample is still on the output register.
  logic [LEN_LOG2:0]   r_ptr;

  logic signed [AW-1:0] acc_r [DEPTH];
  logic signed [AW-1:0] acc_i [DEPTH];

  logic                 accept;
  logic                 last_sample;
  logic signed [AW-1:0] ext_r;
  logic signed [AW-1:0] ext_i;
  logic signed [AW-1:0] sum_r;
  logic signed [AW-1:0] sum_i;

  assign in_ready    = (state == ST_ACCUM);
  assign accept      = in_ready && in_valid;
  assign last_sample = accept && (&s_cnt) && (&f_cnt);
  assign ext_r       = {{NF_LOG2{in_real[DW-1]}}, in_real};
  assign ext_i       = {{NF_LOG2{in_img[DW-1]}}, in_img};

  // New accumulator value: the first frame overwrites stale RAM contents.
  always_comb begin
    sum_r = ext_r;
    sum_i = ext_i;
    if (f_cnt != '0) begin
      sum_r = acc_r[s_cnt] + ext_r;
      sum_i = acc_i[s_cnt] + ext_i;
    end
  end

  // Accumulator RAM write; contents are deliberately left untouched by reset.
  always_ff @(posedge clk) begin
    if (rst_n && accept) begin
      acc_r[s_cnt] <= sum_r;
      acc_i[s_cnt] <= sum_i;
    end
  end

  // Control: sample/frame counters, dump sequencing, registered output, drop flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_ACCUM;
      s_cnt     <= '0;
      f_cnt     <= '0;
      r_ptr     <= '0;
      out_valid <= 1'b0;
      out_real  <= '0;
      out_img   <= '0;
      out_idx   <= '0;
      err_drop  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        ST_ACCUM: begin
          if (accept) begin
            s_cnt <= s_cnt + 1'b1;
            if (&s_cnt) begin
              f_cnt <= f_cnt + 1'b1;
            end
            if (last_sample) begin
              state <= ST_DUMP;
              r_ptr <= '0;
            end
          end
        end
        default: begin
          if (in_valid) begin
            err_drop <= 1'b1;
          end
          if (!r_ptr[LEN_LOG2]) begin
            out_valid <= 1'b1;
            out_idx   <= r_ptr[LEN_LOG2-1:0];
            out_real  <= acc_r[r_ptr[LEN_LOG2-1:0]][AW-1:NF_LOG2];
            out_img   <= acc_i[r_ptr[LEN_LOG2-1:0]][AW-1:NF_LOG2];
            r_ptr     <= r_ptr + 1'b1;
          end else begin
            state <= ST_ACCUM;
          end
        end
      endcase
    end
  end

endmodule
